xxx_apb_timer: RTL and testbench
================================

// Module: xxx_apb_timer
// PURPOSE
//  APB3 slave hosting a 32-bit down-counting timer with reload, interrupt and ID register.
//  Sits on the peripheral APB bus, clocked by the APB clock (pclk, 50 MHz nominal, 20 ns period).
//  Software programs LOAD and CTRL, polls COUNT/STATUS, and takes irq on expiry.
// PARAMETERS
//  ADDR_W   12            APB address width; decode uses paddr[4:2], paddr[ADDR_W-1:5] must be 0
//  DATA_W   32            APB data width; fixed at 32
//  ID_VALUE 32'h5858_0100 constant returned by ID register
// PORTS
//  pclk     in   1       APB clock; sole clock
//  presetn  in   1       synchronous active-low reset
//  psel     in   1       APB select
//  penable  in   1       APB access phase
//  pwrite   in   1       1=write, 0=read
//  paddr    in   ADDR_W  byte address
//  pwdata   in   DATA_W  write data
//  prdata   out  DATA_W  read data, valid when psel&penable&pready
//  pready   out  1       always 1 (zero wait states)
//  pslverr  out  1       error on unmapped address
//  irq      out  1       level interrupt = STATUS.pend & CTRL.irq_en
// BEHAVIOUR
//  Reset (presetn low at posedge pclk): CTRL=0, LOAD=0, COUNT=0, STATUS=0; prdata=0, pslverr=0, irq=0.
//  Register map (word aligned):
//   0x00 CTRL   RW  [0]=en [1]=irq_en [2]=auto_reload; other bits read 0
//   0x04 LOAD   RW  reload value
//   0x08 COUNT  RO  current count; writes ignored, no error
//   0x0C STATUS W1C [0]=pend; writing 1 clears, 0 no effect
//   0x10 ID     RO  ID_VALUE
//   other   -> pslverr=1, prdata=0, no state change
//  Access: write commits on posedge where psel&penable&pwrite. Read data is combinational from the
//   decoded register during the access phase; 0 when not selected. pslverr is asserted only in the
//   access phase.
//  Writing LOAD also loads COUNT with pwdata on the same edge.
//  Counting: when en=1 and COUNT!=0, COUNT decrements by 1 per pclk.
//  Expiry: on the edge where COUNT transitions 1->0, pend is set.
//   If auto_reload=1, COUNT reloads to LOAD on the next edge instead of staying at 0;
//   otherwise COUNT holds at 0 and en stays set.
//   LOAD=0 with auto_reload: COUNT stays 0 and no further pend is raised.
//  Simultaneous events: a hardware pend set in the same cycle as a W1C clear leaves pend=1 (set wins).
//   A LOAD write in the same cycle as a decrement or reload leaves COUNT = the written value.
//  en 1->0 freezes COUNT; re-enable resumes from the frozen value.
//  Reset asserted mid-count clears everything on the next edge; no residual irq.
//  irq is registered: it follows pend&irq_en with 1-cycle latency after the pend update.
// STRUCTURE
//  Package xxx_pkg: address offsets (CTRL_OFS..ID_OFS), CTRL bit indices, ID_VALUE default,
//   and typedef ctrl_t (packed struct en/irq_en/auto_reload).
//  Sub-module xxx_apb_if: APB decode, write strobes, read mux, pslverr.
//  The top level holds the registers and the counter.
// TESTING
//  Reset: hold presetn=0 for 5 clocks, then read 0x00..0x10 -> 0,0,0,0,32'h5858_0100; irq=0.
//  One-shot: LOAD=5, CTRL=3 -> COUNT reaches 0 after 5 clocks, pend=1, irq=1 on the next cycle,
//   COUNT holds at 0.
//  Auto-reload: LOAD=3, CTRL=7 -> pend is set every 4 clocks; writing STATUS=1 drops irq the next cycle.
//  W1C/set race: clear pend on the same edge as a new expiry -> pend stays 1.
//  Bus errors: read/write 0x14 and 0x800 -> pslverr=1, prdata=0, no register changes;
//   write COUNT -> pslverr=0 and COUNT unchanged.
//  Reset mid-count: LOAD=100, en=1, reset at count 60 -> all registers 0, irq=0.

Source files
------------

// File: rtl/xxx_apb_timer_pkg.sv
// Shared definitions for the APB timer.
// Holds the register byte offsets, the CTRL bit positions, the default ID
// value and the ctrl_t layout. The decoder and the top level both import it.
package xxx_pkg;

    localparam int          ADDR_W_DEF   = 12;
    localparam int          DATA_W       = 32;
    localparam logic [31:0] ID_VALUE_DEF = 32'h5858_0100;

    // Byte offsets. Only bits [4:2] select a register.
    localparam logic [4:0] CTRL_OFS   = 5'h00;
    localparam logic [4:0] LOAD_OFS   = 5'h04;
    localparam logic [4:0] COUNT_OFS  = 5'h08;
    localparam logic [4:0] STATUS_OFS = 5'h0C;
    localparam logic [4:0] ID_OFS     = 5'h10;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;
    localparam int CTRL_AR_BIT     = 2;
    localparam int STATUS_PEND_BIT = 0;

    // The member order puts en at bit 0, irq_en at bit 1 and auto_reload at bit 2.
    typedef struct packed {
        logic auto_reload;
        logic irq_en;
        logic en;
    } ctrl_t;

endpackage

// File: rtl/xxx_apb_timer_if.sv
// APB3 bus bundle for the timer.
// The master modport drives psel, penable, pwrite, paddr and pwdata.
// The slave modport drives prdata, pready and pslverr.
interface xxx_apb_timer_if #(
    parameter int ADDR_W = xxx_pkg::ADDR_W_DEF,
    parameter int DATA_W = xxx_pkg::DATA_W
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/xxx_apb_timer_apb_if.sv
// Purely combinational APB decode for the timer.
// Ports:
//   bus         : APB slave. This block drives prdata, pready and pslverr.
//   i_ctrl, i_load, i_count, i_pend : current register values for the read mux.
//   o_wr_ctrl, o_wr_load, o_wr_status : write strobes, one per writable register.
//     A strobe is high during an access phase that will commit on the next pclk edge.
module xxx_apb_if
    import xxx_pkg::*;
#(
    parameter int          ADDR_W   = ADDR_W_DEF,
    parameter logic [31:0] ID_VALUE = ID_VALUE_DEF
) (
    xxx_apb_timer_if.slave    bus,
    input  ctrl_t             i_ctrl,
    input  logic [DATA_W-1:0] i_load,
    input  logic [DATA_W-1:0] i_count,
    input  logic              i_pend,
    output logic              o_wr_ctrl,
    output logic              o_wr_load,
    output logic              o_wr_status
);
    logic              w_access;
    logic              w_hi_zero;
    logic              w_mapped;
    logic              w_wr;
    logic [2:0]        w_idx;
    logic [DATA_W-1:0] w_rdata;

    assign w_access  = bus.psel & bus.penable;
    assign w_hi_zero = (bus.paddr[ADDR_W-1:5] == '0);
    assign w_idx     = bus.paddr[4:2];

    // NOTE: every output of this always_comb is given a default first, so no path can leave a latch behind.
    always_comb begin
        w_rdata  = '0;
        w_mapped = w_hi_zero;
        case (w_idx)
            CTRL_OFS[4:2]:   w_rdata = {{(DATA_W-3){1'b0}}, i_ctrl};
            LOAD_OFS[4:2]:   w_rdata = i_load;
            COUNT_OFS[4:2]:  w_rdata = i_count;
            STATUS_OFS[4:2]: w_rdata = {{(DATA_W-1){1'b0}}, i_pend};
            ID_OFS[4:2]:     w_rdata = ID_VALUE;
            default:         w_mapped = 1'b0;
        endcase
    end

    // An unmapped access produces no strobe, so it cannot change any state.
    assign w_wr        = w_access & bus.pwrite & w_mapped;
    assign o_wr_ctrl   = w_wr & (w_idx == CTRL_OFS[4:2]);
    assign o_wr_load   = w_wr & (w_idx == LOAD_OFS[4:2]);
    assign o_wr_status = w_wr & (w_idx == STATUS_OFS[4:2]);

    assign bus.prdata  = (w_access && w_mapped) ? w_rdata : '0;
    assign bus.pslverr = w_access & ~w_mapped;
    assign bus.pready  = 1'b1;

endmodule

// File: rtl/xxx_apb_timer.sv
// APB3 slave with a 32-bit down-counting timer, reload, interrupt and ID register.
// Ports:
//   pclk    : APB clock. This is the only clock.
//   presetn : synchronous active-low reset.
//   bus     : APB3 slave interface. The interface runs with zero wait states.
//   irq     : registered level interrupt equal to STATUS.pend & CTRL.irq_en.
module xxx_apb_timer
    import xxx_pkg::*;
#(
    parameter int          ADDR_W   = ADDR_W_DEF,
    parameter logic [31:0] ID_VALUE = ID_VALUE_DEF
) (
    input  logic           pclk,
    input  logic           presetn,
    xxx_apb_timer_if.slave bus,
    output logic           irq
);
    ctrl_t             r_ctrl;
    logic [DATA_W-1:0] r_load;
    logic [DATA_W-1:0] r_count;
    logic              r_pend;
    logic              r_irq;

    logic              w_wr_ctrl;
    logic              w_wr_load;
    logic              w_wr_status;
    logic              w_expire;
    logic              w_reload;
    logic              w_pend_clr;
    logic [DATA_W-1:0] w_count_nxt;

    xxx_apb_if #(
        .ADDR_W   (ADDR_W),
        .ID_VALUE (ID_VALUE)
    ) u_apb_if (
        .bus         (bus),
        .i_ctrl      (r_ctrl),
        .i_load      (r_load),
        .i_count     (r_count),
        .i_pend      (r_pend),
        .o_wr_ctrl   (w_wr_ctrl),
        .o_wr_load   (w_wr_load),
        .o_wr_status (w_wr_status)
    );

    // An expiry is the 1->0 step. A LOAD write on the same edge replaces that step, so it is not an expiry.
    assign w_expire   = r_ctrl.en && (r_count == 'd1) && !w_wr_load;
    // A reload happens on the edge after the counter reaches 0. With LOAD=0 the counter keeps reloading 0, and no expiry follows.
    assign w_reload   = r_ctrl.en && r_ctrl.auto_reload && (r_count == '0);
    assign w_pend_clr = w_wr_status && bus.pwdata[STATUS_PEND_BIT];

    always_comb begin
        w_count_nxt = r_count;
        if (w_wr_load) begin
            w_count_nxt = bus.pwdata;
        end else if (w_reload) begin
            w_count_nxt = r_load;
        end else if (r_ctrl.en && (r_count != '0)) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    // NOTE: state uses non-blocking assignments only, so every register samples pre-edge values; reset is tested inside the clocked block.
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            r_ctrl  <= '0;
            r_load  <= '0;
            r_count <= '0;
            r_pend  <= 1'b0;
            r_irq   <= 1'b0;
        end else begin
            if (w_wr_ctrl) r_ctrl <= ctrl_t'(bus.pwdata[2:0]);
            if (w_wr_load) r_load <= bus.pwdata;
            r_count <= w_count_nxt;
            // If a hardware set and a software clear land on the same edge, the set wins.
            r_pend  <= w_expire | (r_pend & ~w_pend_clr);
            r_irq   <= r_pend & r_ctrl.irq_en;
        end
    end

    assign irq = r_irq;

endmodule

// File: tb/tb_xxx_apb_timer.sv
// Self-checking bench for xxx_apb_timer.
// Every bus transaction starts and ends on a falling pclk edge.
// A read samples prdata and pslverr 1 ns into the access phase.
module tb_xxx_apb_timer;

    localparam logic [11:0] A_CTRL   = 12'h000;
    localparam logic [11:0] A_LOAD   = 12'h004;
    localparam logic [11:0] A_COUNT  = 12'h008;
    localparam logic [11:0] A_STATUS = 12'h00C;
    localparam logic [11:0] A_ID     = 12'h010;
    localparam logic [31:0] ID_EXP   = 32'h5858_0100;

    typedef struct {
        string       name;
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        irq;
    logic [31:0] rd;
    logic        err;
    logic        rdy;
    int          n_pass;
    int          n_total;
    int          cycles;
    exp_t        sb[$];
    exp_t        e;

    xxx_apb_timer_if #(.ADDR_W(12), .DATA_W(32)) bus ();

    xxx_apb_timer #(.ADDR_W(12), .ID_VALUE(32'h5858_0100)) dut (
        .pclk    (clk),
        .presetn (rst_n),
        .bus     (bus.slave),
        .irq     (irq)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_exp(input string n, input logic [31:0] d, input logic e_err);
        exp_t x;
        x.name = n;
        x.data = d;
        x.err  = e_err;
        sb.push_back(x);
    endtask

    task automatic bus_write(input logic [11:0] a, input logic [31:0] d, output logic o_err);
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b1;
        bus.paddr   = a;
        bus.pwdata  = d;
        @(negedge clk);
        bus.penable = 1'b1;
        #1 o_err = bus.pslverr;
        @(negedge clk);
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b0;
    endtask

    task automatic bus_read(input logic [11:0] a, output logic [31:0] o_rd, output logic o_err,
                            output logic o_rdy);
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b0;
        bus.paddr   = a;
        @(negedge clk);
        bus.penable = 1'b1;
        #1;
        o_rd  = bus.prdata;
        o_err = bus.pslverr;
        o_rdy = bus.pready;
        @(negedge clk);
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
    endtask

    task automatic test_reset();
        logic [11:0] addrs [5];
        logic [31:0] exps  [5];
        addrs = '{A_CTRL, A_LOAD, A_COUNT, A_STATUS, A_ID};
        exps  = '{32'h0, 32'h0, 32'h0, 32'h0, ID_EXP};
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        n_total++;
        if (irq !== 1'b0) $display("FAIL reset_irq: got %b expected 0", irq);
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            push_exp($sformatf("reset_rd_%0h", addrs[i]), exps[i], 1'b0);
            bus_read(addrs[i], rd, err, rdy);
            e = sb.pop_front();
            n_total++;
            if (rd !== e.data || err !== e.err)
                $display("FAIL %s: got data=%h err=%b expected data=%h err=%b", e.name, rd, err, e.data, e.err);
            else n_pass++;
        end
        n_total++;
        if (rdy !== 1'b1) $display("FAIL pready: got %b expected 1", rdy);
        else n_pass++;
    endtask

    task automatic test_one_shot();
        bus_write(A_LOAD, 32'd5, err);
        bus_write(A_CTRL, 32'd3, err);
        // One decrement has happened by the time the read samples.
        push_exp("oneshot_count_4", 32'd4, 1'b0);
        bus_read(A_COUNT, rd, err, rdy);
        e = sb.pop_front();
        n_total++;
        if (rd !== e.data || err !== e.err)
            $display("FAIL %s: got data=%h err=%b expected data=%h err=%b", e.name, rd, err, e.data, e.err);
        else n_pass++;
        // The counter reaches 0 three edges later and irq follows one edge after that.
        cycles = 0;
        while (irq !== 1'b1 && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        n_total++;
        if (cycles !== 4) $display("FAIL oneshot_irq_latency: got %0d cycles expected 4", cycles);
        else n_pass++;
        push_exp("oneshot_status", 32'd1, 1'b0);
        bus_read(A_STATUS, rd, err, rdy);
        e = sb.pop_front();
        n_total++;
        if (rd !== e.data || err !== e.err)
            $display("FAIL %s: got data=%h err=%b expected data=%h err=%b", e.name, rd, err, e.data, e.err);
        else n_pass++;
        repeat (3) @(negedge clk);
        push_exp("oneshot_count_hold", 32'd0, 1'b0);
        bus_read(A_COUNT, rd, err, rdy);
        e = sb.pop_front();
        n_total++;
        if (rd !== e.data || err !== e.err)
            $display("FAIL %s: got data=%h err=%b expected data=%h err=%b", e.name, rd, err, e.data, e.err);
        else n_pass++;
        n_total++;
        if (irq !== 1'b1) $display("FAIL oneshot_irq_hold: got %b expected 1", irq);
        else n_pass++;
        bus_write(A_STATUS, 32'd1, err);
        bus_write(A_CTRL, 32'd0, err);
        n_total++;
        if (irq !== 1'b0) $display("FAIL oneshot_irq_cleared: got %b expected 0", irq);
        else n_pass++;
    endtask

    task automatic test_auto_reload();
        bus_write(A_LOAD, 32'd3, err);
        bus_write(A_CTRL, 32'd7, err);
        // The counter goes 3,2,1,0 and then reloads, so pend is set every 4 edges.
        cycles = 0;
        while (irq !== 1'b1 && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        n_total++;
        if (cycles !== 4) $display("FAIL reload_first_irq: got %0d cycles expected 4", cycles);
        else n_pass++;
        bus_write(A_STATUS, 32'd1, err);
        n_total++;
        if (irq !== 1'b1) $display("FAIL reload_irq_at_clear: got %b expected 1", irq);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (irq !== 1'b0) $display("FAIL reload_irq_dropped: got %b expected 0", irq);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (irq !== 1'b1) $display("FAIL reload_second_irq: got %b expected 1", irq);
        else n_pass++;
        // This write is placed so that its clear commits on the same edge as the next 1->0 step.
        @(negedge clk);
        bus_write(A_STATUS, 32'd1, err);
        push_exp("race_status", 32'd1, 1'b0);
        bus_read(A_STATUS, rd, err, rdy);
        e = sb.pop_front();
        n_total++;
        if (rd !== e.data || err !== e.err)
            $display("FAIL %s: got data=%h err=%b expected data=%h err=%b", e.name, rd, err, e.data, e.err);
        else n_pass++;
        n_total++;
        if (irq !== 1'b1) $display("FAIL race_irq: got %b expected 1", irq);
        else n_pass++;
        // The counter has gone 0 -> 3 -> 2 -> 1.
        push_exp("reload_count", 32'd1, 1'b0);
        bus_read(A_COUNT, rd, err, rdy);
        e = sb.pop_front();
        n_total++;
        if (rd !== e.data || err !== e.err)
            $display("FAIL %s: got data=%h err=%b expected data=%h err=%b", e.name, rd, err, e.data, e.err);
        else n_pass++;
        bus_write(A_CTRL, 32'd0, err);
        bus_write(A_STATUS, 32'd1, err);
    endtask

    task automatic test_freeze_and_load();
        logic [31:0] exps [3];
        string       names [3];
        bus_write(A_LOAD, 32'd10, err);
        bus_write(A_CTRL, 32'd1, err);
        bus_write(A_CTRL, 32'd0, err);
        exps  = '{32'd8, 32'd8, 32'd7};
        names = '{"freeze_count", "freeze_hold", "resume_count"};
        for (int i = 0; i < 3; i++) begin
            if (i == 1) repeat (3) @(negedge clk);
            if (i == 2) bus_write(A_CTRL, 32'd1, err);
            push_exp(names[i], exps[i], 1'b0);
            bus_read(A_COUNT, rd, err, rdy);
            e = sb.pop_front();
            n_total++;
            if (rd !== e.data || err !== e.err)
                $display("FAIL %s: got data=%h err=%b expected data=%h err=%b", e.name, rd, err, e.data, e.err);
            else n_pass++;
        end
        // A LOAD write lands on an edge where a decrement would also happen, and the written value wins.
        bus_write(A_LOAD, 32'd50, err);
        push_exp("load_priority", 32'd49, 1'b0);
        bus_read(A_COUNT, rd, err, rdy);
        e = sb.pop_front();
        n_total++;
        if (rd !== e.data || err !== e.err)
            $display("FAIL %s: got data=%h err=%b expected data=%h err=%b", e.name, rd, err, e.data, e.err);
        else n_pass++;
        bus_write(A_CTRL, 32'd0, err);
    endtask

    task automatic test_bus_errors();
        logic [11:0] waddr [4];
        logic [31:0] wdata [4];
        logic        werr  [4];
        logic [11:0] raddr [6];
        logic [31:0] rexp  [6];
        logic        rerr  [6];
        bus_write(A_LOAD, 32'h1234, err);
        waddr = '{12'h014, 12'h800, 12'h804, A_COUNT};
        wdata = '{32'hFFFF_FFFF, 32'h7, 32'hDEAD, 32'h55};
        werr  = '{1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            bus_write(waddr[i], wdata[i], err);
            n_total++;
            if (err !== werr[i])
                $display("FAIL wr_err_%0h: got pslverr=%b expected %b", waddr[i], err, werr[i]);
            else n_pass++;
        end
        raddr = '{12'h014, 12'h800, A_CTRL, A_LOAD, A_COUNT, A_STATUS};
        rexp  = '{32'h0, 32'h0, 32'h0, 32'h1234, 32'h1234, 32'h0};
        rerr  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            push_exp($sformatf("err_rd_%0h", raddr[i]), rexp[i], rerr[i]);
            bus_read(raddr[i], rd, err, rdy);
            e = sb.pop_front();
            n_total++;
            if (rd !== e.data || err !== e.err)
                $display("FAIL %s: got data=%h err=%b expected data=%h err=%b", e.name, rd, err, e.data, e.err);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_count();
        logic [11:0] addrs [4];
        addrs = '{A_CTRL, A_LOAD, A_COUNT, A_STATUS};
        bus_write(A_LOAD, 32'd1, err);
        bus_write(A_CTRL, 32'd3, err);
        bus_write(A_LOAD, 32'd100, err);
        repeat (37) @(negedge clk);
        push_exp("mid_count_62", 32'd62, 1'b0);
        bus_read(A_COUNT, rd, err, rdy);
        e = sb.pop_front();
        n_total++;
        if (rd !== e.data || err !== e.err)
            $display("FAIL %s: got data=%h err=%b expected data=%h err=%b", e.name, rd, err, e.data, e.err);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (irq !== 1'b1) $display("FAIL mid_irq_before_reset: got %b expected 1", irq);
        else n_pass++;
        // The counter is at 60 here, and the reset is taken on the next edge.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_total++;
        if (irq !== 1'b0) $display("FAIL mid_irq_after_reset: got %b expected 0", irq);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            push_exp($sformatf("mid_reset_rd_%0h", addrs[i]), 32'h0, 1'b0);
            bus_read(addrs[i], rd, err, rdy);
            e = sb.pop_front();
            n_total++;
            if (rd !== e.data || err !== e.err)
                $display("FAIL %s: got data=%h err=%b expected data=%h err=%b", e.name, rd, err, e.data, e.err);
            else n_pass++;
        end
        repeat (3) @(negedge clk);
        n_total++;
        if (irq !== 1'b0) $display("FAIL mid_irq_stays_low: got %b expected 0", irq);
        else n_pass++;
    endtask

    initial begin
        n_pass      = 0;
        n_total     = 0;
        rst_n       = 1'b0;
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b0;
        bus.paddr   = '0;
        bus.pwdata  = '0;
        @(negedge clk);
        test_reset();
        test_one_shot();
        test_auto_reload();
        test_freeze_and_load();
        test_bus_errors();
        test_reset_mid_count();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
